// File: rtl/ar_rx_buf.sv
// ar_rx_buf - ARINC 429 receive word buffer.
//
// Captures words from the AR_RXD receiver (ce_wr strobe with sr_adr/sr_dat),
// passes them through a masked label filter and queues them in a
// first-word-fall-through FIFO of 2^DEPTH_LOG2 words. Matching words that
// arrive while the FIFO is full (with no simultaneous pop) are discarded and
// counted.
//
// Optional feature: define AR_RXBUF_DUP_FILT_EN to drop an accepted word that
// is identical (label and data) to the last word pushed.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ce_wr           one-cycle word-valid strobe from the receiver
//   sr_adr, sr_dat  received label (8) and data field (23)
//   lbl_val/lbl_msk label compare value and per-bit compare enable
//   rd              pop strobe (ignored while empty)
//   rd_adr, rd_dat  head-of-FIFO word (asynchronous read)
//   empty, full     registered FIFO status
//   count           registered word count (DEPTH_LOG2+1 bits)
//   ovf, ovf_cnt    sticky overflow flag and saturating discard counter
//   clr_ovf         clears ovf/ovf_cnt (a same-cycle overflow wins)
module ar_rx_buf #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_wr,
    input  logic [7:0]            sr_adr,
    input  logic [22:0]           sr_dat,
    input  logic [7:0]            lbl_val,
    input  logic [7:0]            lbl_msk,
    input  logic                  rd,
    output logic [7:0]            rd_adr,
    output logic [22:0]           rd_dat,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf,
    output logic [7:0]            ovf_cnt,
    input  logic                  clr_ovf
);

    localparam int DEPTH_I = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH_I);
    localparam logic [DEPTH_LOG2:0] CNT_ONE_C = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE_C = DEPTH_LOG2'(1);

    logic [30:0]           mem_r [0:DEPTH_I-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   count_nxt_s;
    logic                  empty_r;
    logic                  full_r;
    logic                  ovf_r;
    logic [7:0]            ovf_cnt_r;

    logic                  match_s;
    logic                  dup_s;
    logic                  acc_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  ovf_ev_s;

    assign match_s = ce_wr && (((sr_adr ^ lbl_val) & lbl_msk) == 8'h00);

`ifdef AR_RXBUF_DUP_FILT_EN
    logic [30:0] last_word_r;
    logic        last_vld_r;

    assign dup_s = last_vld_r && (last_word_r == {sr_adr, sr_dat});

    // Remember the last word actually written so repeats can be suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_vld_r  <= 1'b0;
            last_word_r <= 31'h0000_0000;
        end else if (push_s) begin
            last_vld_r  <= 1'b1;
            last_word_r <= {sr_adr, sr_dat};
        end else begin
            last_vld_r  <= last_vld_r;
            last_word_r <= last_word_r;
        end
    end
`else
    assign dup_s = 1'b0;
`endif

    assign acc_s    = match_s && !dup_s;
    assign pop_s    = rd && !empty_r;
    // When full, a same-cycle pop frees the slot, so the push still goes in.
    assign push_s   = acc_s && (!full_r || pop_s);
    assign ovf_ev_s = acc_s && full_r && !pop_s;

    // Next word count from the push/pop combination.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array: no reset, written only on a successful push.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= {sr_adr, sr_dat};
        end
    end

    // Pointers and registered status; status is derived from the next count
    // so empty/full/count always agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == '0);
            full_r  <= (count_nxt_s == DEPTH_C);
        end
    end

    // Sticky overflow flag and saturating discard counter; an overflow in the
    // same cycle as clr_ovf restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r     <= 1'b0;
            ovf_cnt_r <= 8'h00;
        end else if (ovf_ev_s) begin
            ovf_r <= 1'b1;
            if (clr_ovf) begin
                ovf_cnt_r <= 8'h01;
            end else if (ovf_cnt_r == 8'hFF) begin
                ovf_cnt_r <= 8'hFF;
            end else begin
                ovf_cnt_r <= ovf_cnt_r + 8'h01;
            end
        end else if (clr_ovf) begin
            ovf_r     <= 1'b0;
            ovf_cnt_r <= 8'h00;
        end else begin
            ovf_r     <= ovf_r;
            ovf_cnt_r <= ovf_cnt_r;
        end
    end

    assign {rd_adr, rd_dat} = mem_r[rd_ptr_r];
    assign empty   = empty_r;
    assign full    = full_r;
    assign count   = count_r;
    assign ovf     = ovf_r;
    assign ovf_cnt = ovf_cnt_r;

endmodule

// File: tb/tb_ar_rx_buf.sv
// Self-checking bench for ar_rx_buf (DEPTH_LOG2 = 3). A table of vectors with
// constant expectations drives the basic scenarios; a queue scoreboard holds
// the words that should be in the FIFO and is checked against the head every
// cycle. Hand-written sequences cover wrap-around, empty push+pop, reset,
// duplicate filtering and counter saturation.
module tb_ar_rx_buf;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        ce_wr;
    logic [7:0]  sr_adr;
    logic [22:0] sr_dat;
    logic [7:0]  lbl_val;
    logic [7:0]  lbl_msk;
    logic        rd;
    logic [7:0]  rd_adr;
    logic [22:0] rd_dat;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        ovf;
    logic [7:0]  ovf_cnt;
    logic        clr_ovf;

    ar_rx_buf #(.DEPTH_LOG2(3)) dut (
        .clk(clk), .rst(rst), .ce_wr(ce_wr), .sr_adr(sr_adr), .sr_dat(sr_dat),
        .lbl_val(lbl_val), .lbl_msk(lbl_msk), .rd(rd), .rd_adr(rd_adr),
        .rd_dat(rd_dat), .empty(empty), .full(full), .count(count),
        .ovf(ovf), .ovf_cnt(ovf_cnt), .clr_ovf(clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ce;
        logic [7:0]  adr;
        logic [22:0] dat;
        logic [7:0]  val;
        logic [7:0]  msk;
        bit          r;
        bit          clr;
        int          exp_count;
        bit          exp_ovf;
        int          exp_ovf_cnt;
    } vec_t;

    vec_t        vecs[$];
    logic [30:0] sb[$];
    int          n_chk;
    int          n_fail;
    bit          m_ovf;
    int          m_ovf_cnt;
    bit          m_last_vld;
    logic [30:0] m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input bit ce, input logic [7:0] adr, input logic [22:0] dat,
                                input logic [7:0] val, input logic [7:0] msk, input bit r,
                                input bit clr, input int ec, input bit eo, input int eoc);
        vec_t v;
        v.ce = ce; v.adr = adr; v.dat = dat; v.val = val; v.msk = msk;
        v.r = r; v.clr = clr; v.exp_count = ec; v.exp_ovf = eo; v.exp_ovf_cnt = eoc;
        vecs.push_back(v);
    endfunction

    // One clock of stimulus: update the model, clock, then compare.
    task automatic step(input bit ce, input logic [7:0] adr, input logic [22:0] dat,
                        input bit r, input bit clr);
        bit match;
        bit dup;
        ce_wr = ce; sr_adr = adr; sr_dat = dat; rd = r; clr_ovf = clr;
        match = ce && (((adr ^ lbl_val) & lbl_msk) == 8'h00);
        dup = 1'b0;
`ifdef AR_RXBUF_DUP_FILT_EN
        dup = m_last_vld && (m_last == {adr, dat});
`endif
        if (r && sb.size() != 0) void'(sb.pop_front());
        if (clr) begin
            m_ovf = 1'b0;
            m_ovf_cnt = 0;
        end
        if (match && !dup) begin
            if (sb.size() < DEPTH) begin
                sb.push_back({adr, dat});
                m_last = {adr, dat};
                m_last_vld = 1'b1;
            end else begin
                m_ovf = 1'b1;
                m_ovf_cnt = (m_ovf_cnt == 255) ? 255 : m_ovf_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
        ce_wr = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
        chk("count", 32'(count), 32'(sb.size()));
        chk("empty", 32'(empty), 32'(sb.size() == 0));
        chk("full", 32'(full), 32'(sb.size() == DEPTH));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf_cnt));
        if (sb.size() != 0) chk("head", 32'({rd_adr, rd_dat}), 32'(sb[0]));
    endtask

    // Reset with a write and a read strobe held high in the reset cycle.
    task automatic do_reset();
        rst = 1'b1; ce_wr = 1'b1; rd = 1'b1; sr_adr = 8'h77; sr_dat = 23'h00_0777;
        @(posedge clk);
        #1;
        rst = 1'b0; ce_wr = 1'b0; rd = 1'b0;
        sb.delete();
        m_ovf = 1'b0; m_ovf_cnt = 0; m_last_vld = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 23'h0, 1'b1, 1'b0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        m_ovf = 1'b0; m_ovf_cnt = 0; m_last_vld = 1'b0; m_last = 31'h0;
        rst = 1'b1; ce_wr = 1'b0; sr_adr = 8'h00; sr_dat = 23'h0;
        lbl_val = 8'h00; lbl_msk = 8'h00; rd = 1'b0; clr_ovf = 1'b0;

        // Vector table, applied in order from reset.
        add(1'b1, 8'h0A, 23'h12345, 8'h00, 8'h00, 1'b0, 1'b0, 1, 1'b0, 0);
        add(1'b0, 8'h00, 23'h0,     8'h00, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0);
        add(1'b1, 8'h30, 23'h1,     8'h31, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 0);
        add(1'b1, 8'h31, 23'h7,     8'h31, 8'hFF, 1'b0, 1'b0, 1, 1'b0, 0);
        add(1'b1, 8'h32, 23'h2,     8'h31, 8'hFF, 1'b0, 1'b0, 1, 1'b0, 0);
        add(1'b0, 8'h00, 23'h0,     8'h31, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0);
        for (int i = 1; i <= 10; i++)
            add(1'b1, 8'h40 + 8'(i), 23'(i), 8'h00, 8'h00, 1'b0, 1'b0,
                (i > 8) ? 8 : i, i > 8, (i > 8) ? i - 8 : 0);
        add(1'b1, 8'h01, 23'h5,  8'h00, 8'hFF, 1'b0, 1'b0, 8, 1'b1, 2);
        add(1'b0, 8'h00, 23'h0,  8'h00, 8'h00, 1'b0, 1'b1, 8, 1'b0, 0);
        add(1'b1, 8'h4B, 23'h11, 8'h00, 8'h00, 1'b1, 1'b0, 8, 1'b0, 0);
        add(1'b1, 8'h4C, 23'h12, 8'h00, 8'h00, 1'b0, 1'b1, 8, 1'b1, 1);
        add(1'b0, 8'h00, 23'h0,  8'h00, 8'h00, 1'b0, 1'b1, 8, 1'b0, 0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);

        foreach (vecs[i]) begin
            lbl_val = vecs[i].val;
            lbl_msk = vecs[i].msk;
            step(vecs[i].ce, vecs[i].adr, vecs[i].dat, vecs[i].r, vecs[i].clr);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_ovf_cnt", i), 32'(ovf_cnt), 32'(vecs[i].exp_ovf_cnt));
        end

        // Full FIFO: interleaved push/pop across pointer wrap, then drain.
        lbl_val = 8'h00; lbl_msk = 8'h00;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'h80 + 8'(i), 23'h100 + 23'(i), 1'b1, 1'b0);
            chk("wrap_count", 32'(count), 32'd8);
        end
        drain();
        chk("drain_empty", 32'(empty), 32'd1);

        // Empty FIFO with simultaneous push and pop keeps the word.
        step(1'b1, 8'h5A, 23'h2A5A5, 1'b1, 1'b0);
        chk("emp_pp_count", 32'(count), 32'd1);
        chk("emp_pp_word", 32'({rd_adr, rd_dat}), 32'({8'h5A, 23'h2A5A5}));
        drain();

        // Reset mid-operation with five words held.
        for (int i = 0; i < 5; i++) step(1'b1, 8'h20 + 8'(i), 23'(i + 50), 1'b0, 1'b0);
        do_reset();
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_full", 32'(full), 32'd0);
        step(1'b1, 8'h66, 23'h00666, 1'b0, 1'b0);
        step(1'b1, 8'h67, 23'h00667, 1'b1, 1'b0);
        drain();

        // Duplicate words.
        step(1'b1, 8'h0A, 23'h00001, 1'b0, 1'b0);
        step(1'b1, 8'h0A, 23'h00001, 1'b0, 1'b0);
        step(1'b1, 8'h0A, 23'h00002, 1'b0, 1'b0);
`ifdef AR_RXBUF_DUP_FILT_EN
        chk("dup_count", 32'(count), 32'd2);
`else
        chk("dup_count", 32'(count), 32'd3);
`endif
        drain();

        // Discard counter saturates at 255.
        for (int i = 0; i < DEPTH + 260; i++) step(1'b1, 8'h90, 23'(i), 1'b0, 1'b0);
        chk("sat_ovf_cnt", 32'(ovf_cnt), 32'd255);
        chk("sat_count", 32'(count), 32'd8);
        step(1'b0, 8'h00, 23'h0, 1'b0, 1'b1);
        chk("sat_clr", 32'(ovf_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
